// File: rtl/vuart_axilite_bridge_pkg.sv
// Shared register map, status bit positions and FSM state encoding for the
// virtual UART AXI-lite bridge.
package vuart_axilite_bridge_pkg;

    localparam logic [31:0] VUART_RX_OFF     = 32'h0;
    localparam logic [31:0] VUART_TX_OFF     = 32'h4;
    localparam logic [31:0] VUART_STATUS_OFF = 32'h8;

    localparam int RX_VALID = 0;
    localparam int RX_FULL  = 1;
    localparam int TX_EMPTY = 2;
    localparam int TX_FULL  = 3;
    localparam int INT_EN   = 4;

    typedef enum logic [2:0] {
        IDLE,
        ST_AR,
        ST_R,
        TX_AW,
        TX_B,
        RX_AR,
        RX_R
    } vuart_bridge_state_t;

endpackage

// File: rtl/vuart_axilite_bridge_fifo.sv
// First-word fall-through byte FIFO; one extra pointer bit separates full from empty.
module sync_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clock_i,
    input  logic       reset_ni,
    input  logic [7:0] push_data,
    input  logic       push_valid,
    output logic       full,
    output logic [7:0] pop_data,
    input  logic       pop_ready,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push_valid && !full;
    assign do_pop   = pop_ready && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/vuart_axilite_bridge.sv
// AXI-lite master moving bytes between a valid/ready byte stream and a virtual
// UART register file, one transaction at a time, gated by the STATUS register.
module vuart_axilite_bridge
    import vuart_axilite_bridge_pkg::*;
#(
    parameter int                          LOCAL_DATA_WIDTH = 32,
    parameter int                          LOCAL_ADDR_WIDTH = 32,
    parameter logic [LOCAL_ADDR_WIDTH-1:0] BASE_ADDR        = '0,
    parameter int                          TX_FIFO_DEPTH    = 8,
    parameter int                          RX_FIFO_DEPTH    = 8,
    parameter int                          POLL_INTERVAL    = 64
) (
    input  logic                          clock_i,
    input  logic                          reset_ni,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic                          err_o,
    output logic [LOCAL_ADDR_WIDTH-1:0]   m_axilite_awaddr,
    output logic                          m_axilite_awvalid,
    input  logic                          m_axilite_awready,
    output logic [LOCAL_DATA_WIDTH-1:0]   m_axilite_wdata,
    output logic [LOCAL_DATA_WIDTH/8-1:0] m_axilite_wstrb,
    output logic                          m_axilite_wvalid,
    input  logic                          m_axilite_wready,
    input  logic [1:0]                    m_axilite_bresp,
    input  logic                          m_axilite_bvalid,
    output logic                          m_axilite_bready,
    output logic [LOCAL_ADDR_WIDTH-1:0]   m_axilite_araddr,
    output logic                          m_axilite_arvalid,
    input  logic                          m_axilite_arready,
    input  logic [LOCAL_DATA_WIDTH-1:0]   m_axilite_rdata,
    input  logic [1:0]                    m_axilite_rresp,
    input  logic                          m_axilite_rvalid,
    output logic                          m_axilite_rready
);
    localparam int STRB_W = LOCAL_DATA_WIDTH / 8;
    localparam int PW     = $clog2(POLL_INTERVAL + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_INTERVAL);

    vuart_bridge_state_t state_q;
    logic [PW-1:0]       poll_cnt_q;
    logic                ready_en_q;
    logic [7:0]          tx_head;
    logic                tx_full, tx_empty, tx_pop;
    logic                rx_full, rx_empty, rx_push;
    logic                unused_rdata;

    assign tx_pop       = (state_q == TX_B) && m_axilite_bvalid;
    assign rx_push      = (state_q == RX_R) && m_axilite_rvalid && (m_axilite_rresp == 2'b00);
    assign tx_ready_o   = ready_en_q && !tx_full;
    assign rx_valid_o   = !rx_empty;
    assign unused_rdata = ^m_axilite_rdata[LOCAL_DATA_WIDTH-1:8];

    sync_byte_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .push_data  (tx_data_i),
        .push_valid (tx_valid_i && tx_ready_o),
        .full       (tx_full),
        .pop_data   (tx_head),
        .pop_ready  (tx_pop),
        .empty      (tx_empty)
    );

    sync_byte_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .push_data  (m_axilite_rdata[7:0]),
        .push_valid (rx_push),
        .full       (rx_full),
        .pop_data   (rx_data_o),
        .pop_ready  (rx_ready_i),
        .empty      (rx_empty)
    );

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q           <= IDLE;
            poll_cnt_q        <= '0;
            ready_en_q        <= 1'b0;
            err_o             <= 1'b0;
            m_axilite_awaddr  <= '0;
            m_axilite_awvalid <= 1'b0;
            m_axilite_wdata   <= '0;
            m_axilite_wstrb   <= '0;
            m_axilite_wvalid  <= 1'b0;
            m_axilite_bready  <= 1'b0;
            m_axilite_araddr  <= '0;
            m_axilite_arvalid <= 1'b0;
            m_axilite_rready  <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            err_o      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (poll_cnt_q != POLL_MAX) poll_cnt_q <= poll_cnt_q + 1'b1;
                    if (!tx_empty || poll_cnt_q == POLL_MAX) begin
                        state_q           <= ST_AR;
                        m_axilite_araddr  <= BASE_ADDR + LOCAL_ADDR_WIDTH'(VUART_STATUS_OFF);
                        m_axilite_arvalid <= 1'b1;
                    end
                end
                ST_AR: if (m_axilite_arready) begin
                    m_axilite_arvalid <= 1'b0;
                    m_axilite_rready  <= 1'b1;
                    state_q           <= ST_R;
                end
                ST_R: if (m_axilite_rvalid) begin
                    m_axilite_rready <= 1'b0;
                    poll_cnt_q       <= '0;
                    if (m_axilite_rresp != 2'b00) begin
                        err_o   <= 1'b1;
                        state_q <= IDLE;
                    end else if (!tx_empty && !m_axilite_rdata[TX_FULL]) begin
                        state_q           <= TX_AW;
                        m_axilite_awaddr  <= BASE_ADDR + LOCAL_ADDR_WIDTH'(VUART_TX_OFF);
                        m_axilite_wdata   <= LOCAL_DATA_WIDTH'(tx_head);
                        m_axilite_wstrb   <= STRB_W'(1);
                        m_axilite_awvalid <= 1'b1;
                        m_axilite_wvalid  <= 1'b1;
                    end else if (m_axilite_rdata[RX_VALID] && !rx_full) begin
                        state_q           <= RX_AR;
                        m_axilite_araddr  <= BASE_ADDR + LOCAL_ADDR_WIDTH'(VUART_RX_OFF);
                        m_axilite_arvalid <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                TX_AW: begin
                    // AW and W complete independently; move on once neither is pending.
                    if (m_axilite_awready) m_axilite_awvalid <= 1'b0;
                    if (m_axilite_wready)  m_axilite_wvalid  <= 1'b0;
                    if ((!m_axilite_awvalid || m_axilite_awready) &&
                        (!m_axilite_wvalid  || m_axilite_wready)) begin
                        m_axilite_bready <= 1'b1;
                        state_q          <= TX_B;
                    end
                end
                TX_B: if (m_axilite_bvalid) begin
                    m_axilite_bready <= 1'b0;
                    err_o            <= (m_axilite_bresp != 2'b00);
                    state_q          <= IDLE;
                end
                RX_AR: if (m_axilite_arready) begin
                    m_axilite_arvalid <= 1'b0;
                    m_axilite_rready  <= 1'b1;
                    state_q           <= RX_R;
                end
                RX_R: if (m_axilite_rvalid) begin
                    m_axilite_rready <= 1'b0;
                    err_o            <= (m_axilite_rresp != 2'b00);
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vuart_axilite_bridge.sv
// Self-checking bench: a virtual UART slave model checks every AXI transaction
// against an expected-transaction queue filled by the test tasks.
module tb_vuart_axilite_bridge;
    import vuart_axilite_bridge_pkg::*;

    localparam int POLL = 64;

    logic        clock_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [7:0]  tx_data_i = '0;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic        err_o;
    logic [31:0] m_axilite_awaddr;
    logic        m_axilite_awvalid;
    logic        m_axilite_awready = 1'b1;
    logic [31:0] m_axilite_wdata;
    logic [3:0]  m_axilite_wstrb;
    logic        m_axilite_wvalid;
    logic        m_axilite_wready = 1'b1;
    logic [1:0]  m_axilite_bresp = '0;
    logic        m_axilite_bvalid = 1'b0;
    logic        m_axilite_bready;
    logic [31:0] m_axilite_araddr;
    logic        m_axilite_arvalid;
    logic        m_axilite_arready = 1'b1;
    logic [31:0] m_axilite_rdata = '0;
    logic [1:0]  m_axilite_rresp = '0;
    logic        m_axilite_rvalid = 1'b0;
    logic        m_axilite_rready;

    vuart_axilite_bridge dut (
        .clock_i(clock_i), .reset_ni(reset_ni),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .err_o(err_o),
        .m_axilite_awaddr(m_axilite_awaddr), .m_axilite_awvalid(m_axilite_awvalid),
        .m_axilite_awready(m_axilite_awready),
        .m_axilite_wdata(m_axilite_wdata), .m_axilite_wstrb(m_axilite_wstrb),
        .m_axilite_wvalid(m_axilite_wvalid), .m_axilite_wready(m_axilite_wready),
        .m_axilite_bresp(m_axilite_bresp), .m_axilite_bvalid(m_axilite_bvalid),
        .m_axilite_bready(m_axilite_bready),
        .m_axilite_araddr(m_axilite_araddr), .m_axilite_arvalid(m_axilite_arvalid),
        .m_axilite_arready(m_axilite_arready),
        .m_axilite_rdata(m_axilite_rdata), .m_axilite_rresp(m_axilite_rresp),
        .m_axilite_rvalid(m_axilite_rvalid), .m_axilite_rready(m_axilite_rready)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } axi_txn_t;

    axi_txn_t    exp_q[$];
    logic [31:0] status_q[$];
    logic [31:0] status_dflt = 32'h4;
    logic [7:0]  rx_byte = 8'h00;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    bit          sb_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          err_cnt = 0;
    int          err_long = 0;
    bit          err_prev = 1'b0;

    // Slave model: samples on the falling edge, responses appear one cycle after the handshake.
    initial begin : slave
        bit          ar_taken, r_drop, b_drop, b_rise, aw_seen, w_seen;
        logic [31:0] ar_addr_l, rd_addr_cur, wr_addr_l, wr_data_l;
        logic [3:0]  wr_strb_l;
        axi_txn_t    e;
        ar_taken = 0; r_drop = 0; b_drop = 0; b_rise = 0; aw_seen = 0; w_seen = 0;
        ar_addr_l = '0; rd_addr_cur = '0; wr_addr_l = '0; wr_data_l = '0; wr_strb_l = '0;
        forever begin
            @(negedge clock_i);
            if (!reset_ni) begin
                ar_taken = 0; r_drop = 0; b_drop = 0; b_rise = 0; aw_seen = 0; w_seen = 0;
                m_axilite_rvalid = 1'b0; m_axilite_bvalid = 1'b0;
                m_axilite_rdata = '0; m_axilite_rresp = '0; m_axilite_bresp = '0;
                err_prev = 1'b0;
                continue;
            end
            if (err_o) begin
                err_cnt++;
                if (err_prev) err_long++;
            end
            err_prev = err_o;
            if (r_drop) begin m_axilite_rvalid = 1'b0; r_drop = 0; end
            if (b_drop) begin m_axilite_bvalid = 1'b0; b_drop = 0; end
            if (ar_taken) begin
                ar_taken = 0;
                rd_addr_cur = ar_addr_l;
                m_axilite_rvalid = 1'b1;
                m_axilite_rresp = rresp_cfg;
                if (ar_addr_l == 32'h8)
                    m_axilite_rdata = (status_q.size() != 0) ? status_q.pop_front() : status_dflt;
                else
                    m_axilite_rdata = {24'h0, rx_byte};
            end
            if (b_rise) begin b_rise = 0; m_axilite_bvalid = 1'b1; m_axilite_bresp = bresp_cfg; end

            if (m_axilite_arvalid && m_axilite_arready) begin ar_taken = 1; ar_addr_l = m_axilite_araddr; end
            if (m_axilite_awvalid && m_axilite_awready) begin aw_seen = 1; wr_addr_l = m_axilite_awaddr; end
            if (m_axilite_wvalid && m_axilite_wready) begin
                w_seen = 1; wr_data_l = m_axilite_wdata; wr_strb_l = m_axilite_wstrb;
            end
            if (aw_seen && w_seen) begin aw_seen = 0; w_seen = 0; b_rise = 1; end
            if (m_axilite_rvalid && m_axilite_rready) begin
                r_drop = 1;
                if (sb_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_read unexpected read addr=%h", rd_addr_cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_write || e.addr !== rd_addr_cur) begin
                            errors++;
                            $display("FAIL sb_read got read addr=%h expected write=%0d addr=%h",
                                     rd_addr_cur, e.is_write, e.addr);
                        end
                    end
                end
            end
            if (m_axilite_bvalid && m_axilite_bready) begin
                b_drop = 1;
                if (sb_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_write unexpected write addr=%h data=%h", wr_addr_l, wr_data_l);
                    end else begin
                        e = exp_q.pop_front();
                        if (!e.is_write || e.addr !== wr_addr_l || e.data !== wr_data_l || e.strb !== wr_strb_l) begin
                            errors++;
                            $display("FAIL sb_write got addr=%h data=%h strb=%h expected write=%0d addr=%h data=%h strb=%h",
                                     wr_addr_l, wr_data_l, wr_strb_l, e.is_write, e.addr, e.data, e.strb);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic exp_read(input logic [31:0] a);
        axi_txn_t t;
        t.is_write = 0; t.addr = a; t.data = '0; t.strb = '0;
        exp_q.push_back(t);
    endtask

    task automatic exp_write(input logic [7:0] b);
        axi_txn_t t;
        t.is_write = 1; t.addr = 32'h4; t.data = {24'h0, b}; t.strb = 4'h1;
        exp_q.push_back(t);
    endtask

    // Ends on the first falling edge after release, before any clock edge with reset high.
    task automatic apply_reset();
        @(posedge clock_i); #1;
        reset_ni = 1'b0;
        tx_valid_i = 1'b0; rx_ready_i = 1'b0; sb_en = 1'b0;
        m_axilite_arready = 1'b1; m_axilite_awready = 1'b1; m_axilite_wready = 1'b1;
        exp_q.delete(); status_q.delete();
        status_dflt = 32'h4; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        err_cnt = 0; err_long = 0;
        repeat (3) @(posedge clock_i);
        #1 reset_ni = 1'b1;
        @(negedge clock_i);
    endtask

    // Called on a falling edge; returns on a falling edge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        tx_data_i = b; tx_valid_i = 1'b1;
        while (!tx_ready_o && n < 400) begin @(negedge clock_i); n++; end
        if (!tx_ready_o) begin
            checks++; errors++;
            $display("FAIL send_byte timeout byte=%h", b);
        end
        @(negedge clock_i);
        tx_valid_i = 1'b0;
    endtask

    task automatic wait_sb_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin @(negedge clock_i); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(posedge clock_i); #1 reset_ni = 1'b0;
        #2;
        checks++;
        if ({m_axilite_awvalid, m_axilite_wvalid, m_axilite_bready, m_axilite_arvalid,
             m_axilite_rready, tx_ready_o, rx_valid_o, err_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got=%b required=00000000",
                     {m_axilite_awvalid, m_axilite_wvalid, m_axilite_bready, m_axilite_arvalid,
                      m_axilite_rready, tx_ready_o, rx_valid_o, err_o});
        end
        checks++;
        if (m_axilite_awaddr !== 32'h0 || m_axilite_araddr !== 32'h0 || m_axilite_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_payload awaddr=%h araddr=%h wdata=%h required=0",
                     m_axilite_awaddr, m_axilite_araddr, m_axilite_wdata);
        end
        checks++;
        if (dut.state_q !== IDLE || dut.poll_cnt_q !== '0) begin
            errors++;
            $display("FAIL reset_fsm state=%0d poll=%0d required=0/0", dut.state_q, dut.poll_cnt_q);
        end
        apply_reset();
        checks++;
        if (tx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early got=%b required=0", tx_ready_o);
        end
        @(negedge clock_i);
        checks++;
        if (tx_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise got=%b required=1", tx_ready_o);
        end
    endtask

    task automatic test_tx_basic();
        int rdy_low = 0;
        apply_reset();
        status_dflt = 32'h4;
        exp_read(32'h8); exp_write(8'h41);
        sb_en = 1'b1;
        send_byte(8'h41);
        repeat (30) begin
            @(negedge clock_i);
            if (!tx_ready_o) rdy_low++;
        end
        sb_en = 1'b0;
        wait_sb_empty("tx_basic_sb", 1);
        checks++;
        if (rdy_low != 0 || err_cnt != 0) begin
            errors++;
            $display("FAIL tx_basic_flags ready_low=%0d err=%0d required=0/0", rdy_low, err_cnt);
        end
    endtask

    task automatic test_tx_full_retry();
        apply_reset();
        status_q.push_back(32'h8); status_q.push_back(32'h8);
        status_q.push_back(32'h8); status_q.push_back(32'h4);
        status_dflt = 32'h4;
        repeat (4) exp_read(32'h8);
        exp_write(8'h33);
        sb_en = 1'b1;
        send_byte(8'h33);
        wait_sb_empty("tx_retry_sb", 60);
        repeat (10) @(negedge clock_i);
        sb_en = 1'b0;
    endtask

    task automatic test_rx_poll();
        int n = 0;
        apply_reset();
        status_q.push_back(32'h1);
        status_dflt = 32'h0;
        rx_byte = 8'h5A;
        exp_read(32'h8); exp_read(32'h0);
        sb_en = 1'b1;
        while (!m_axilite_arvalid && n < 200) begin @(negedge clock_i); n++; end
        checks++;
        if (n != POLL + 1) begin
            errors++;
            $display("FAIL rx_poll_delay got=%0d required=%0d", n, POLL + 1);
        end
        n = 0;
        while (!rx_valid_o && n < 20) begin @(negedge clock_i); n++; end
        checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h5A) begin
            errors++;
            $display("FAIL rx_data valid=%b data=%h required=1/5a", rx_valid_o, rx_data_o);
        end
        wait_sb_empty("rx_sb", 1);
        repeat (5) @(negedge clock_i);
        sb_en = 1'b0;
        checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h5A) begin
            errors++;
            $display("FAIL rx_hold valid=%b data=%h required=1/5a", rx_valid_o, rx_data_o);
        end
        rx_ready_i = 1'b1;
        @(negedge clock_i);
        rx_ready_i = 1'b0;
        checks++;
        if (rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rx_pop valid=%b required=0", rx_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int rdy_high = 0;
        apply_reset();
        @(posedge clock_i); #1 m_axilite_arready = 1'b0;
        @(negedge clock_i);
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
        checks++;
        if (tx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full ready=%b required=0", tx_ready_o);
        end
        tx_data_i = 8'h18; tx_valid_i = 1'b1;
        repeat (10) begin
            @(negedge clock_i);
            if (tx_ready_o) rdy_high++;
        end
        checks++;
        if (rdy_high != 0) begin
            errors++;
            $display("FAIL b2b_hold ready_high=%0d required=0", rdy_high);
        end
        for (int i = 0; i < 9; i++) begin
            exp_read(32'h8);
            exp_write(8'h10 + 8'(i));
        end
        status_dflt = 32'h4;
        @(posedge clock_i); #1;
        sb_en = 1'b1;
        m_axilite_arready = 1'b1;
        @(negedge clock_i);
        send_byte(8'h18);
        wait_sb_empty("b2b_sb", 400);
        sb_en = 1'b0;
    endtask

    task automatic test_bresp_err();
        apply_reset();
        bresp_cfg = 2'b10;
        status_dflt = 32'h4;
        exp_read(32'h8); exp_write(8'h77);
        sb_en = 1'b1;
        send_byte(8'h77);
        repeat (30) @(negedge clock_i);
        sb_en = 1'b0;
        wait_sb_empty("bresp_sb", 1);
        checks++;
        if (err_cnt != 1 || err_long != 0) begin
            errors++;
            $display("FAIL bresp_err pulses=%0d long=%0d required=1/0", err_cnt, err_long);
        end
        checks++;
        if (dut.state_q !== IDLE || dut.tx_empty !== 1'b1) begin
            errors++;
            $display("FAIL bresp_state state=%0d tx_empty=%b required=0/1", dut.state_q, dut.tx_empty);
        end
        bresp_cfg = 2'b00;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        apply_reset();
        @(posedge clock_i); #1 m_axilite_awready = 1'b0;
        @(negedge clock_i);
        send_byte(8'h55);
        send_byte(8'h66);
        while (!m_axilite_awvalid && n < 40) begin @(negedge clock_i); n++; end
        checks++;
        if (m_axilite_awvalid !== 1'b1 || dut.state_q !== TX_AW) begin
            errors++;
            $display("FAIL mid_pre awvalid=%b state=%0d required=1/%0d", m_axilite_awvalid, dut.state_q, TX_AW);
        end
        @(posedge clock_i); #1 reset_ni = 1'b0;
        #1;
        checks++;
        if (m_axilite_awvalid !== 1'b0 || m_axilite_wvalid !== 1'b0 ||
            dut.tx_empty !== 1'b1 || dut.rx_empty !== 1'b1 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL mid_reset awvalid=%b wvalid=%b tx_empty=%b rx_empty=%b state=%0d required=0/0/1/1/0",
                     m_axilite_awvalid, m_axilite_wvalid, dut.tx_empty, dut.rx_empty, dut.state_q);
        end
        repeat (2) @(posedge clock_i);
        #1 m_axilite_awready = 1'b1; reset_ni = 1'b1;
        repeat (2) @(negedge clock_i);
        checks++;
        if (dut.state_q !== IDLE || tx_ready_o !== 1'b1 || m_axilite_awvalid !== 1'b0 || m_axilite_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release state=%0d ready=%b awvalid=%b arvalid=%b required=0/1/0/0",
                     dut.state_q, tx_ready_o, m_axilite_awvalid, m_axilite_arvalid);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_full_retry();
        test_rx_poll();
        test_back_to_back();
        test_bresp_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
